immgen_pipe: RTL and testbench
==============================

Name: immgen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It accepts 32-bit instructions over a valid/ready handshake and decodes I, S, B, U and J immediates. Each immediate is sign-extended to XLEN. Results are delivered one cycle later through a 2-entry skid buffer, so upstream never sees a combinational ready path from downstream. Sits between fetch/instruction buffer and register-read.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 4, width of sideband tag carried alongside each instruction (e.g. ROB/PC index).
CNT_W, 16, width of illegal-opcode counter (optional feature only).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  instruction valid
in_ready  out  1  block can accept instruction
in_inst  in  32  instruction word
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_imm  out  XLEN  sign-extended immediate
out_type  out  3  imm_type_e: NONE=0, I=1, S=2, B=3, U=4, J=5
out_illegal  out  1  opcode not in decoded set
out_tag  out  TAG_W  tag of this result
illegal_cnt  out  CNT_W  only with IMMGEN_ILLEGAL_CNT_EN

Behaviour:
- Opcode decode (inst[6:0]):
  - I: 0010011, 0000011, 1100111 -> {inst[31] ext, inst[31:20]}
  - S: 0100011 -> {ext, inst[31:25], inst[11:7]}
  - B: 1100011 -> {ext, inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: 0110111, 0010111 -> {ext, inst[31:12], 12'b0}
  - J: 1101111 -> {ext, inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type 0110011 -> NONE, imm=0, illegal=0
  - Any other opcode -> NONE, imm=0, illegal=1
- Sign extension: all sign extension uses inst[31]. For XLEN=64, U-type is sign-extended from bit 31.
- Accept: transfer occurs when in_valid && in_ready. Decode is combinational on in_inst; the result is registered.
- Latency: exactly 1 cycle from accept to out_valid when the buffer is empty.
- Emit: out_valid && out_ready completes a transfer. Outputs are stable while out_valid && !out_ready.
- Buffer state machine. Entries are OUT (the presented register) and SKID.
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && emit -> ONE (OUT reloaded)
    - accept && !emit -> TWO (new result to SKID)
    - emit only -> EMPTY
  - TWO: in_ready=0. Emit -> ONE, with SKID moved to OUT the same cycle.
- in_ready = (state != TWO); it is a registered function of state only.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- flush: next state EMPTY and both entries invalidated, overriding any simultaneous accept or emit. in_ready=1 the following cycle. A transfer completing in the flush cycle is still counted as delivered by the consumer.
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_type=NONE, out_illegal=0, out_tag=0, illegal_cnt=0.
- rst asserted mid-stream discards all in-flight entries; rst has priority over flush.
- Data registers need no reset except where listed above.

Optional Feature:
IMMGEN_ILLEGAL_CNT_EN
- Defined:
  - illegal_cnt port exists.
  - It increments by 1 on each accepted instruction whose decode is illegal.
  - It saturates at all-ones.
  - It is cleared by rst only; flush does not clear it.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- immgen_pkg holds:
  - imm_type_e enum
  - opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP)
  - imm_result_t struct {imm, type, illegal, tag}, parametrised via XLEN/TAG_W in the module
- Sub-module immgen_decode: purely combinational, inst -> imm_result_t fields. It is instantiated once; immgen_pipe holds the skid buffer and state machine.

Test Plan:
- Types at XLEN=32, out_ready=1, one cycle after each accept:
  - 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, type I
  - 0xFE112E23 (sw -4) -> 0xFFFFFFFC, S
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, B
  - 0x123452B7 (lui) -> 0x12345000, U
  - 0x001000EF (jal +2048) -> 0x00000800, J
- XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. 0x800002B7 -> 0xFFFFFFFF80000000.
- Backpressure: out_ready=0 with 3 back-to-back valid inputs (tags 1,2,3):
  - tags 1 and 2 are accepted; in_ready=0 from cycle 2
  - release out_ready -> outputs appear in tag order 1,2,3, with no bubbles after release
  - out_imm is stable while stalled
- Illegal: 0x0000007F -> out_illegal=1, type NONE, imm 0. 0x00B50533 (add) -> illegal=0, NONE. With IMMGEN_ILLEGAL_CNT_EN, illegal_cnt=1 after this pair; CNT_W=2 with 5 illegals -> 3.
- Flush/reset: in state TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input is not emitted. Repeat with rst -> all outputs at reset values.

Source files
------------

// File: rtl/immgen_pkg.sv
// immgen_pkg: shared types for the immediate generator.
// Immediate type encoding, RV32 opcodes, skid-buffer state.
package immgen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/immgen_pipe_decode.sv
// immgen_decode: combinational inst -> immediate/type/illegal.
// Ports: inst in; imm (XLEN, sign-extended), typ, illegal out.
module immgen_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       typ,
  output logic            illegal
);

  logic [6:0]  op;
  logic [31:0] imm32;
  logic        i31;
  logic        is_i;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;
  logic        is_r;

  assign op   = inst[6:0];
  assign i31  = inst[31];
  assign is_i = (op == OP_IMM) ||
                (op == LOAD) ||
                (op == JALR);
  assign is_s = (op == STORE);
  assign is_b = (op == BRANCH);
  assign is_u = (op == LUI) ||
                (op == AUIPC);
  assign is_j = (op == JAL);
  assign is_r = (op == OP);

  always_comb begin
    imm32   = '0;
    typ     = IMM_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        typ   = IMM_I;
        imm32 = {{20{i31}}, inst[31:20]};
      end
      is_s: begin
        typ   = IMM_S;
        imm32 = {{20{i31}}, inst[31:25],
                 inst[11:7]};
      end
      is_b: begin
        typ   = IMM_B;
        imm32 = {{19{i31}}, i31, inst[7],
                 inst[30:25], inst[11:8],
                 1'b0};
      end
      is_u: begin
        typ   = IMM_U;
        imm32 = {inst[31:12], 12'b0};
      end
      is_j: begin
        typ   = IMM_J;
        imm32 = {{11{i31}}, i31,
                 inst[19:12], inst[20],
                 inst[30:21], 1'b0};
      end
      is_r: begin
        typ = IMM_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // bit 31 of every immediate is inst[31]; widen from it
  assign imm = {{(XLEN-31){imm32[31]}},
                imm32[30:0]};

endmodule

// File: rtl/immgen_pipe.sv
// immgen_pipe: registered immediate generator, 2-entry skid.
// Ports: clk/rst/flush, in_* valid/ready, out_* result;
// illegal_cnt only with IMMGEN_ILLEGAL_CNT_EN defined.
module immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_type_e        out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } imm_result_t;

  buf_state_e  state_q;
  buf_state_e  state_d;
  imm_result_t out_q;
  imm_result_t out_d;
  imm_result_t skid_q;
  imm_result_t skid_d;
  imm_result_t dec;
  logic        acc;
  logic        emit;

  immgen_decode #(
    .XLEN (XLEN)
  ) u_dec (
    .inst    (in_inst),
    .imm     (dec.imm),
    .typ     (dec.typ),
    .illegal (dec.illegal)
  );
  assign dec.tag = in_tag;

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign acc       = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (acc) begin
          out_d   = dec;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (acc && emit) begin
          out_d = dec;
        end else if (acc) begin
          skid_d  = dec;
          state_d = S_TWO;
        end else if (emit) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (emit) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign out_imm     = out_q.imm;
  assign out_type    = out_q.typ;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

`ifdef IMMGEN_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && dec.illegal &&
        (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed + random bench for immgen_pipe.
// Runs XLEN=32 and XLEN=64 instances side by side.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        r32, v32, il32;
  logic [31:0] imm32;
  logic [2:0]  ty32;
  logic [3:0]  tg32;
  logic        r64, v64, il64;
  logic [63:0] imm64;
  logic [2:0]  ty64;
  logic [3:0]  tg64;
`ifdef IMMGEN_ILLEGAL_CNT_EN
  logic [1:0]  cnt32;
  logic [1:0]  cnt64;
`endif

  always #5 clk = ~clk;

  immgen_pipe #(
    .XLEN(32), .TAG_W(4), .CNT_W(2)
  ) d32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_type(ty32),
    .out_illegal(il32), .out_tag(tg32)
`ifdef IMMGEN_ILLEGAL_CNT_EN
    , .illegal_cnt(cnt32)
`endif
  );

  immgen_pipe #(
    .XLEN(64), .TAG_W(4), .CNT_W(2)
  ) d64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(ty64),
    .out_illegal(il64), .out_tag(tg64)
`ifdef IMMGEN_ILLEGAL_CNT_EN
    , .illegal_cnt(cnt64)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   cnt_m = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             name, obs, exp);
    end
  endtask

  // reference: immediates by signed arithmetic on the fields
  function automatic exp_t model(
    input logic [31:0] inst,
    input logic [3:0]  tag);
    exp_t   e;
    longint s;
    longint hi;
    s = longint'($signed(inst));
    hi = s >>> 31;
    e.imm = '0;
    e.typ = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.typ = 3'd1;
        e.imm = s >>> 20;
      end
      7'h23: begin
        e.typ = 3'd2;
        e.imm = (s >>> 25) * 32 +
                longint'(inst[11:7]);
      end
      7'h63: begin
        e.typ = 3'd3;
        e.imm = hi * 4096 +
                longint'(inst[7]) * 2048 +
                longint'(inst[30:25]) * 32 +
                longint'(inst[11:8]) * 2;
      end
      7'h37, 7'h17: begin
        e.typ = 3'd4;
        e.imm = (s >>> 12) * 4096;
      end
      7'h6F: begin
        e.typ = 3'd5;
        e.imm = hi * 1048576 +
                longint'(inst[19:12]) * 4096 +
                longint'(inst[20]) * 2048 +
                longint'(inst[30:21]) * 2;
      end
      7'h33: ;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // one clock: drive, sample before edge, update model
  task automatic cycle(input logic v,
                       input logic [31:0] inst,
                       input logic [3:0] tag,
                       input logic ordy,
                       input logic fl,
                       input logic r);
    exp_t e;
    bit   acc;
    bit   emit;
    rst = r;
    flush = fl;
    in_valid = v;
    in_inst = inst;
    in_tag = tag;
    out_ready = ordy;
    #1;
    if (!r) begin
      chk("in_ready32", 64'(r32), 64'(q.size() < 2));
      chk("in_ready64", 64'(r64), 64'(q.size() < 2));
      chk("out_valid32", 64'(v32), 64'(q.size() > 0));
      chk("out_valid64", 64'(v64), 64'(q.size() > 0));
`ifdef IMMGEN_ILLEGAL_CNT_EN
      chk("cnt32", 64'(cnt32), 64'(cnt_m));
      chk("cnt64", 64'(cnt64), 64'(cnt_m));
`endif
      if (q.size() > 0) begin
        chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
        chk("imm64", imm64, q[0].imm);
        chk("type32", 64'(ty32), 64'(q[0].typ));
        chk("type64", 64'(ty64), 64'(q[0].typ));
        chk("ill32", 64'(il32), 64'(q[0].ill));
        chk("tag32", 64'(tg32), 64'(q[0].tag));
        chk("tag64", 64'(tg64), 64'(q[0].tag));
      end
      acc = v && (q.size() < 2);
      emit = ordy && (q.size() > 0);
      if (emit) void'(q.pop_front());
      if (acc) begin
        e = model(inst, tag);
        q.push_back(e);
        if (e.ill && cnt_m < 3) cnt_m++;
      end
      if (fl) q.delete();
    end else begin
      q.delete();
      cnt_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'h0, 4'h0, ordy, 1'b0, 1'b0);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_valid"}, 64'(v32), 64'd0);
    chk({n, "_ready"}, 64'(r32), 64'd1);
    chk({n, "_imm"}, 64'(imm32), 64'd0);
    chk({n, "_type"}, 64'(ty32), 64'd0);
    chk({n, "_ill"}, 64'(il32), 64'd0);
    chk({n, "_tag"}, 64'(tg32), 64'd0);
    chk({n, "_imm64"}, imm64, 64'd0);
`ifdef IMMGEN_ILLEGAL_CNT_EN
    chk({n, "_cnt"}, 64'(cnt32), 64'd0);
`endif
  endtask

  task automatic directed(input string n,
                          input logic [31:0] inst,
                          input logic [31:0] e32,
                          input logic [63:0] e64,
                          input logic [2:0] et,
                          input logic eil);
    cycle(1'b1, inst, 4'hA, 1'b1, 1'b0, 1'b0);
    chk({n, "_v"}, 64'(v32), 64'd1);
    chk({n, "_imm"}, 64'(imm32), 64'(e32));
    chk({n, "_imm64"}, imm64, e64);
    chk({n, "_type"}, 64'(ty32), 64'(et));
    chk({n, "_ill"}, 64'(il32), 64'(eil));
    idle(1'b1);
  endtask

  logic [6:0]  ops [12];
  logic [31:0] saved;
  logic [31:0] ri;

  initial begin
    ops = '{7'h13, 7'h03, 7'h67, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h7F, 7'h0B, 7'h00};
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk_reset("rst0");

    directed("addi", 32'hFFF00093, 32'hFFFFFFFF,
             64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    directed("sw", 32'hFE112E23, 32'hFFFFFFFC,
             64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    directed("beq", 32'hFE000CE3, 32'hFFFFFFF8,
             64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    directed("lui", 32'h123452B7, 32'h12345000,
             64'h0000000012345000, 3'd4, 1'b0);
    directed("jal", 32'h001000EF, 32'h00000800,
             64'h0000000000000800, 3'd5, 1'b0);
    directed("lui64", 32'h800002B7, 32'h80000000,
             64'hFFFFFFFF80000000, 3'd4, 1'b0);
    directed("bad", 32'h0000007F, 32'h0,
             64'h0, 3'd0, 1'b1);
    directed("add", 32'h00B50533, 32'h0,
             64'h0, 3'd0, 1'b0);
`ifdef IMMGEN_ILLEGAL_CNT_EN
    chk("cnt_pair", 64'(cnt32), 64'd1);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h0000007F, 4'h1, 1'b1,
            1'b0, 1'b0);
    idle(1'b1);
    chk("cnt_sat", 64'(cnt32), 64'd3);
`endif

    // backpressure: three back-to-back, consumer stalled
    cycle(1'b1, 32'hFFF00093, 4'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 4'd2, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy_c2", 64'(r32), 64'd0);
    chk("bp_tag_c2", 64'(tg32), 64'd1);
    saved = imm32;
    cycle(1'b1, 32'h123452B7, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("bp_rdy_c3", 64'(r32), 64'd0);
    chk("bp_stable", 64'(imm32), 64'(saved));
    cycle(1'b1, 32'h123452B7, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_tag2", 64'(tg32), 64'd2);
    cycle(1'b1, 32'h123452B7, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("bp_rel_tag3", 64'(tg32), 64'd3);
    chk("bp_rel_v3", 64'(v32), 64'd1);
    idle(1'b1);
    chk("bp_drained", 64'(v32), 64'd0);

    // flush while full, with a valid input present
    cycle(1'b1, 32'hFFF00093, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE000CE3, 4'd6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h001000EF, 4'd7, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", 64'(v32), 64'd0);
    chk("fl_ready", 64'(r32), 64'd1);
    idle(1'b1);
    chk("fl_noemit", 64'(v32), 64'd0);

    // flush overriding accept+emit
    cycle(1'b1, 32'hFFF00093, 4'd8, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 4'd9, 1'b1, 1'b1, 1'b0);
    chk("fl1_valid", 64'(v32), 64'd0);
    idle(1'b1);

    // reset while full
    cycle(1'b1, 32'hFFF00093, 4'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000007F, 4'd6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h001000EF, 4'd7, 1'b0, 1'b1, 1'b1);
    chk_reset("rst1");
    idle(1'b1);

    for (int i = 0; i < 600; i++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) != 0)
        ri[6:0] = ops[$urandom_range(0, 11)];
      cycle($urandom_range(0, 3) != 0, ri,
            4'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 40) == 0, 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 64'(v32), 64'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
